hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock (single clock domain).
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: imem_ready  in  1  instruction memory holds valid fetch data this cycle.
REQ-004 SHALL have: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have: id_uses_rt  in  1  ID instruction reads rt; id_is_branch  in  1  ID instruction is a branch resolved in ID.
REQ-006 SHALL have: id_taken  in  1  branch taken or jump, resolved in ID.
REQ-007 SHALL have: idex_memread, idex_regwrite  in  1 each; idex_dst  in  5  destination register in EX.
REQ-008 SHALL have: exmem_memread  in  1; exmem_dst  in  5  destination register in MEM.
REQ-009 SHALL have: c_PCWrite, c_IFIDWrite, c_if_flush, c_idex_bubble  out  1 each  pipeline controls to the PC, IF/ID and ID/EX registers.
REQ-010 SHALL have: stall_busy  out  1  high while the FSM is in STALL.

Function
REQ-011 match(d) SHALL be (d != 0) & ((d == id_rs) | (id_uses_rt & d == id_rt)).
REQ-012 Stall length N SHALL be the maximum of the following (0 if none applies): 2 if id_is_branch & idex_memread & match(idex_dst); 1 if idex_memread & match(idex_dst); 1 if id_is_branch & idex_regwrite & match(idex_dst); 1 if id_is_branch & exmem_memread & match(exmem_dst).
REQ-013 FSM states SHALL be RUN and STALL, with a 2-bit remaining-cycle counter cnt.
REQ-014 In RUN with N>0: stall outputs this cycle (c_PCWrite=0, c_IFIDWrite=0, c_if_flush=0, c_idex_bubble=1); if N=2, go to STALL with cnt=1; otherwise stay in RUN.
REQ-015 In STALL: stall outputs; all hazard, imem_ready and id_taken inputs ignored; cnt decrements each cycle; return to RUN on the cycle cnt reaches 0.
REQ-016 In RUN with N=0: c_idex_bubble=0, c_IFIDWrite=1, c_PCWrite = imem_ready | id_taken, c_if_flush = ~imem_ready | id_taken.
REQ-017 Priority in RUN SHALL be: data stall > taken redirect/imem wait > normal flow. id_taken is ignored whenever N>0.
REQ-018 An imem wait without a redirect SHALL insert a nop into ID (flush) and hold the PC; a redirect during an imem wait SHALL still load the PC (c_PCWrite=1).
REQ-019 All control outputs SHALL be combinational from the state and the current inputs; state and cnt SHALL be the only registers, except the statistics counters.

Reset
REQ-020 rst SHALL force state=RUN and cnt=0 immediately, independent of clk.
REQ-021 While rst is high, outputs SHALL be: c_PCWrite=0, c_IFIDWrite=0, c_if_flush=0, c_idex_bubble=1, stall_busy=0.
REQ-022 Reset asserted mid-STALL SHALL abandon the remaining stall; the first cycle after release is evaluated in RUN.

Configuration
REQ-023 Macro HAZARD_CTRL_STATS_EN: when defined, the module SHALL add outputs stat_stall_cycles and stat_flushes (out, 32 bits each). stat_stall_cycles increments on every cycle with c_idex_bubble=1 outside reset. stat_flushes increments on every cycle where id_taken causes a flush. Both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-024 When the macro is undefined, the module SHALL have neither these ports nor these registers; all other behaviour is unchanged.

Structure
REQ-025 Package hazard_pkg SHALL hold the RUN/STALL state encoding, the register-number width (5) and the counter width (2).
REQ-026 Sub-module hazard_match SHALL implement match(d) and be instantiated once for the EX destination and once for the MEM destination.

Verification
REQ-027 Load-use: idex_memread=1, idex_dst=8, id_rs=8 -> one cycle of PCWrite=0, IFIDWrite=0, bubble=1; next cycle (idex inputs cleared) normal flow.
REQ-028 Load then branch: id_is_branch=1, idex_memread=1, idex_dst=9, id_rt=9, id_uses_rt=1 -> 2 stall cycles, stall_busy=1 in the second; id_taken=1 in either cycle produces no flush.
REQ-029 $zero: idex_memread=1, idex_dst=0, id_rs=0 -> no stall.
REQ-030 Redirect during wait: imem_ready=0, id_taken=1, no hazard -> PCWrite=1, IFIDWrite=1, if_flush=1, bubble=0; with imem_ready=0 and id_taken=0 -> PCWrite=0, if_flush=1.
REQ-031 Reset during the second stall cycle -> outputs take reset values immediately; after release, N=0 gives PCWrite=1 and IFIDWrite=1.
REQ-032 With HAZARD_CTRL_STATS_EN defined: 3 stall cycles + 2 taken flushes -> stat_stall_cycles=3 and stat_flushes=2; with a counter preloaded to 0xFFFFFFFF, a further stall cycle leaves it at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;
  localparam int REG_W = 5;
  localparam int CNT_W = 2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle.
// Handshake: no valid/ready pairs here; all inputs are sampled every cycle and
// the control outputs are combinational from current state and inputs.
interface hazard_ctrl_if import hazard_pkg::*; ();
  logic             imem_ready;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_taken;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [REG_W-1:0] idex_dst;
  logic             exmem_memread;
  logic [REG_W-1:0] exmem_dst;
  logic             c_PCWrite;
  logic             c_IFIDWrite;
  logic             c_if_flush;
  logic             c_idex_bubble;
  logic             stall_busy;
  state_t           state;

  modport slave (
    input  imem_ready, id_rs, id_rt, id_uses_rt, id_is_branch, id_taken,
           idex_memread, idex_regwrite, idex_dst, exmem_memread, exmem_dst,
    output c_PCWrite, c_IFIDWrite, c_if_flush, c_idex_bubble, stall_busy, state
  );

  modport master (
    output imem_ready, id_rs, id_rt, id_uses_rt, id_is_branch, id_taken,
           idex_memread, idex_regwrite, idex_dst, exmem_memread, exmem_dst,
    input  c_PCWrite, c_IFIDWrite, c_if_flush, c_idex_bubble, stall_busy, state
  );
endinterface

// File: rtl/hazard_match.sv
// True when a nonzero destination register feeds a source operand of the ID instruction.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rt,
  output logic             hit
);
  assign hit = (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: data stalls, imem waits and ID-stage redirects.
// Optional macro HAZARD_CTRL_STATS_EN adds saturating stall/flush statistics counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [31:0]   stat_stall_cycles,
  output logic [31:0]   stat_flushes
`endif
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_ex, hit_mem;
  logic [1:0]       stall_n;
  logic             pc_write, ifid_write, if_flush, idex_bubble, taken_flush;

  hazard_match u_match_ex (
    .dst     (bus.idex_dst),
    .rs      (bus.id_rs),
    .rt      (bus.id_rt),
    .uses_rt (bus.id_uses_rt),
    .hit     (hit_ex)
  );

  hazard_match u_match_mem (
    .dst     (bus.exmem_dst),
    .rs      (bus.id_rs),
    .rt      (bus.id_rt),
    .uses_rt (bus.id_uses_rt),
    .hit     (hit_mem)
  );

  // A branch resolved in ID waiting on a load needs the value out of MEM: two cycles.
  always_comb begin
    stall_n = 2'd0;
    if (bus.id_is_branch && bus.idex_memread && hit_ex)
      stall_n = 2'd2;
    else if ((bus.idex_memread && hit_ex) ||
             (bus.id_is_branch && bus.idex_regwrite && hit_ex) ||
             (bus.id_is_branch && bus.exmem_memread && hit_mem))
      stall_n = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    if_flush    = 1'b0;
    idex_bubble = 1'b1;
    taken_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (stall_n != 2'd0) begin
          if (stall_n == 2'd2) begin
            state_d = STALL;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          idex_bubble = 1'b0;
          ifid_write  = 1'b1;
          pc_write    = bus.imem_ready | bus.id_taken;
          if_flush    = ~bus.imem_ready | bus.id_taken;
          taken_flush = bus.id_taken;
        end
      end
      STALL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0)
          state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Reset outputs hold the pipeline frozen with a bubble into EX.
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      if_flush    = 1'b0;
      idex_bubble = 1'b1;
      taken_flush = 1'b0;
    end
  end

  assign bus.c_PCWrite     = pc_write;
  assign bus.c_IFIDWrite   = ifid_write;
  assign bus.c_if_flush    = if_flush;
  assign bus.c_idex_bubble = idex_bubble;
  assign bus.stall_busy    = (state_q == STALL) && !rst;
  assign bus.state         = state_q;

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (idex_bubble && (stat_stall_cycles != 32'hFFFF_FFFF))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (taken_flush && (stat_flushes != 32'hFFFF_FFFF))
        stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  hazard_ctrl_if bus ();

`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_flushes;
  longint      m_stall_cnt = 0;
  longint      m_flush_cnt = 0;
`endif

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_CTRL_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_flushes      (stat_flushes)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: extra forced stall cycles still owed after the current one
  int         stall_left = 0;
  logic [4:0] exp_q[$];

  function automatic logic [4:0] got_vec();
    return {bus.c_PCWrite, bus.c_IFIDWrite, bus.c_if_flush, bus.c_idex_bubble, bus.stall_busy};
  endfunction

  function automatic logic m_match(logic [4:0] d);
    return (d != 5'd0) && ((d == bus.id_rs) || (bus.id_uses_rt && d == bus.id_rt));
  endfunction

  function automatic int model_n();
    int n;
    n = 0;
    if (bus.idex_memread && m_match(bus.idex_dst)) n = 1;
    if (bus.id_is_branch && bus.idex_regwrite && m_match(bus.idex_dst)) n = 1;
    if (bus.id_is_branch && bus.exmem_memread && m_match(bus.exmem_dst)) n = 1;
    if (bus.id_is_branch && bus.idex_memread && m_match(bus.idex_dst)) n = 2;
    return n;
  endfunction

  task automatic check5(string name, logic [4:0] got, logic [4:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got {pcw,ifidw,flush,bubble,busy}=%b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic lit(string name, logic [4:0] exp);
    check5(name, got_vec(), exp);
  endtask

  // scoreboard / compare process, once per cycle at the falling edge
  always @(negedge clk) begin
    logic [4:0] e;
    logic       normal;
    int         n;
    normal = 1'b0;
    if (rst) begin
      e = 5'b00010;
      stall_left = 0;
    end else if (stall_left > 0) begin
      e = 5'b00011;
      stall_left--;
    end else begin
      n = model_n();
      if (n > 0) begin
        e = 5'b00010;
        stall_left = n - 1;
      end else begin
        normal = 1'b1;
        e = {bus.imem_ready | bus.id_taken, 1'b1, ~bus.imem_ready | bus.id_taken, 1'b0, 1'b0};
      end
    end
    exp_q.push_back(e);
    check5("cycle", got_vec(), exp_q.pop_front());
`ifdef HAZARD_CTRL_STATS_EN
    if (rst) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end
    check32("stat_stall", stat_stall_cycles, m_stall_cnt[31:0]);
    check32("stat_flush", stat_flushes, m_flush_cnt[31:0]);
    if (!rst) begin
      if (e[1] && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (normal && bus.id_taken && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
    end
`else
    if (normal && rst) $display("unreachable");
`endif
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.imem_ready    = 1'b1;
    bus.id_rs         = 5'd0;
    bus.id_rt         = 5'd0;
    bus.id_uses_rt    = 1'b0;
    bus.id_is_branch  = 1'b0;
    bus.id_taken      = 1'b0;
    bus.idex_memread  = 1'b0;
    bus.idex_regwrite = 1'b0;
    bus.idex_dst      = 5'd0;
    bus.exmem_memread = 1'b0;
    bus.exmem_dst     = 5'd0;
  endtask

  task automatic load_branch();
    clear_in();
    bus.id_is_branch = 1'b1;
    bus.idex_memread = 1'b1;
    bus.idex_dst     = 5'd9;
    bus.id_rt        = 5'd9;
    bus.id_uses_rt   = 1'b1;
    bus.id_taken     = 1'b1;
  endtask

  task automatic rand_in();
    bus.imem_ready    = ($urandom_range(0, 3) != 0);
    bus.id_rs         = 5'($urandom_range(0, 3));
    bus.id_rt         = 5'($urandom_range(0, 3));
    bus.id_uses_rt    = 1'($urandom_range(0, 1));
    bus.id_is_branch  = 1'($urandom_range(0, 1));
    bus.id_taken      = 1'($urandom_range(0, 1));
    bus.idex_memread  = 1'($urandom_range(0, 1));
    bus.idex_regwrite = 1'($urandom_range(0, 1));
    bus.idex_dst      = 5'($urandom_range(0, 3));
    bus.exmem_memread = 1'($urandom_range(0, 1));
    bus.exmem_dst     = 5'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #2 lit("reset_outputs", 5'b00010);
    step(); rst = 1'b0; clear_in();
    #2 lit("first_run", 5'b11000);

    step(); clear_in(); bus.idex_memread = 1'b1; bus.idex_dst = 5'd8; bus.id_rs = 5'd8;
    #2 lit("load_use", 5'b00010);
    step(); clear_in();
    #2 lit("load_use_release", 5'b11000);

    step(); load_branch();
    #2 lit("ld_br_cycle1", 5'b00010);
    step(); load_branch();
    #2 lit("ld_br_cycle2", 5'b00011);
    step(); clear_in();
    #2 lit("ld_br_release", 5'b11000);

    step(); clear_in(); bus.idex_memread = 1'b1; bus.idex_dst = 5'd0; bus.id_rs = 5'd0;
    #2 lit("zero_reg", 5'b11000);

    step(); clear_in(); bus.imem_ready = 1'b0; bus.id_taken = 1'b1;
    #2 lit("redirect_in_wait", 5'b11100);
    step(); clear_in(); bus.imem_ready = 1'b0;
    #2 lit("imem_wait", 5'b01100);
    step(); clear_in(); bus.id_taken = 1'b1;
    #2 lit("taken_ready", 5'b11100);

    step(); clear_in(); bus.id_is_branch = 1'b1; bus.idex_regwrite = 1'b1;
    bus.idex_dst = 5'd5; bus.id_rs = 5'd5; bus.id_taken = 1'b1;
    #2 lit("branch_alu_dep", 5'b00010);
    step(); clear_in(); bus.id_is_branch = 1'b1; bus.exmem_memread = 1'b1;
    bus.exmem_dst = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    #2 lit("branch_mem_load", 5'b00010);
    step(); bus.id_uses_rt = 1'b0;
    #2 lit("rt_not_used", 5'b11000);

    step(); load_branch();
    #2 lit("rst_stall1", 5'b00010);
    step(); load_branch();
    #2 lit("rst_stall2", 5'b00011);
    rst = 1'b1;
    #1 lit("rst_mid_stall", 5'b00010);
    step(); rst = 1'b0; clear_in();
    #2 lit("rst_release", 5'b11000);

`ifdef HAZARD_CTRL_STATS_EN
    step(); rst = 1'b1; clear_in();
    step(); rst = 1'b0;
    step(); clear_in(); bus.idex_memread = 1'b1; bus.idex_dst = 5'd8; bus.id_rs = 5'd8;
    step(); load_branch();
    step(); load_branch();
    step(); clear_in(); bus.id_taken = 1'b1;
    step(); clear_in(); bus.id_taken = 1'b1;
    step(); clear_in();
    #2 check32("stat_stall_lit", stat_stall_cycles, 32'd3);
    check32("stat_flush_lit", stat_flushes, 32'd2);
`endif

    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 39) == 0);
      rand_in();
    end
    step(); rst = 1'b0; clear_in();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
